// File: rtl/drop_tick_scheduler.sv
// Drop tick scheduler: paces the falling piece by raising step_req once per
// drop period (level- or soft-drop-derived) and holding it until step_ack.
module drop_tick_scheduler #(
  parameter int CNT_W       = 24,
  parameter int LEVEL_W     = 4,
  parameter int BASE_PERIOD = 12_500_000,
  parameter int LEVEL_STEP  = 781_250,
  parameter int MIN_PERIOD  = 1_250_000,
  parameter int SOFT_PERIOD = 625_000
) (
  input  logic               clk,
  input  logic               clr_n,
  input  logic               start,
  input  logic               stop,
  input  logic               pause,
  input  logic               soft_drop,
  input  logic [LEVEL_W-1:0] level,
  input  logic               level_load,
  input  logic               step_ack,
  output logic               step_req,
  output logic               running,
  output logic               paused,
  output logic [3:0]         missed,
  output logic [CNT_W-1:0]   period_cur
);

  localparam int PW = CNT_W + LEVEL_W;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    RUN     = 2'd1,
    PENDING = 2'd2,
    PAUSED  = 2'd3
  } state_t;

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [CNT_W-1:0]   period_q, period_d;
  logic               req_q, req_d;
  logic [3:0]         missed_q, missed_d;
  logic [LEVEL_W-1:0] level_q, level_d;
  logic               soft_q;

  logic [PW-1:0]      lvl_prod;
  logic [PW-1:0]      lvl_wide;
  logic [CNT_W-1:0]   lvl_period;
  logic [CNT_W-1:0]   eff_period;
  logic               edges_live;
  logic               soft_rise;
  logic               soft_fall;
  logic               expire;

  // Level period is clamped at the floor instead of being allowed to wrap.
  assign lvl_prod   = {{CNT_W{1'b0}}, level_q} * PW'(LEVEL_STEP);
  assign lvl_wide   = (lvl_prod > PW'(BASE_PERIOD - MIN_PERIOD)) ? PW'(MIN_PERIOD)
                                                                 : PW'(BASE_PERIOD) - lvl_prod;
  assign lvl_period = lvl_wide[CNT_W-1:0];
  assign eff_period = soft_drop ? CNT_W'(SOFT_PERIOD) : lvl_period;

  assign edges_live = (state_q == RUN) || (state_q == PENDING);
  assign soft_rise  = edges_live && soft_drop && !soft_q;
  assign soft_fall  = edges_live && !soft_drop && soft_q;
  assign expire     = cnt_q >= (period_q - CNT_W'(1));

  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      period_q <= CNT_W'(BASE_PERIOD);
      req_q    <= 1'b0;
      missed_q <= '0;
      level_q  <= '0;
      soft_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      period_q <= period_d;
      req_q    <= req_d;
      missed_q <= missed_d;
      level_q  <= level_d;
      soft_q   <= soft_drop;
    end
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    period_d = period_q;
    req_d    = req_q;
    missed_d = missed_q;
    level_d  = level_load ? level : level_q;

    if (stop) begin
      state_d  = IDLE;
      cnt_d    = '0;
      req_d    = 1'b0;
      missed_d = '0;
    end else if (pause) begin
      if (state_q != IDLE) begin
        state_d = PAUSED;
        if (step_ack) req_d = 1'b0;
      end
    end else if (state_q == IDLE) begin
      if (start) begin
        state_d  = RUN;
        cnt_d    = '0;
        period_d = eff_period;
      end
    end else begin
      // Soft-drop edges take precedence over expiry in the cycle they occur.
      if (soft_rise) begin
        cnt_d    = '0;
        period_d = CNT_W'(SOFT_PERIOD);
        if (step_ack) req_d = 1'b0;
      end else if (soft_fall) begin
        period_d = lvl_period;
        if (step_ack) req_d = 1'b0;
      end else if (expire) begin
        cnt_d    = '0;
        period_d = eff_period;
        req_d    = 1'b1;
        if (req_q && !step_ack && (missed_q != 4'd15)) missed_d = missed_q + 4'd1;
      end else begin
        cnt_d = cnt_q + CNT_W'(1);
        if (step_ack) req_d = 1'b0;
      end
      state_d = req_d ? PENDING : RUN;
    end
  end

  assign step_req   = req_q;
  assign running    = (state_q == RUN) || (state_q == PENDING);
  assign paused     = (state_q == PAUSED);
  assign missed     = missed_q;
  assign period_cur = period_q;

endmodule
